// File: rtl/store_buffer_if.sv
// Core-side store/load-forward handshake and memory-side write port of the
// store buffer, bundled so the core and the buffer see the same widths.
interface store_buffer_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [AW-1:0] st_data;
   logic          st_ready;
   logic [AW-1:0] ld_addr;
   logic          ld_hit;
   logic [AW-1:0] ld_data;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] mem_wdata;
   logic          mem_ack;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;

   modport master (
      output st_valid, st_addr, st_data, ld_addr, mem_ack,
      input  st_ready, ld_hit, ld_data, mem_req, mem_addr, mem_wdata, count, empty, full
   );

   modport slave (
      input  st_valid, st_addr, st_data, ld_addr, mem_ack,
      output st_ready, ld_hit, ld_data, mem_req, mem_addr, mem_wdata, count, empty, full
   );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: queues core stores, drains them in order to data
// memory through a two-state FSM, and forwards the youngest match to loads.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          CLK,
   input  logic          reset,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   logic [DEPTH-1:0][AW-1:0] addr_q, data_q;
   logic [DEPTH-1:0]         valid_q;
   logic [PW-1:0]            head, tail;
   logic [CW-1:0]            count_q, count_n;
   state_t                   state;
   logic                     full, enq, pop;

   assign full    = (count_q == CW'(DEPTH));
   assign enq     = sb.st_valid && !full;
   assign pop     = (state == REQ) && sb.mem_ack;
   assign count_n = count_q + CW'(enq) - CW'(pop);

   assign sb.full     = full;
   assign sb.empty    = (count_q == '0);
   assign sb.st_ready = !full;
   assign sb.count    = count_q;
   assign sb.mem_req  = (state == REQ);
   assign sb.mem_addr  = (state == REQ) ? addr_q[head] : '0;
   assign sb.mem_wdata = (state == REQ) ? data_q[head] : '0;

   // Payload carries no reset; only valid bits decide what is live.
   always_ff @(posedge CLK) begin
      if (enq) begin
         addr_q[tail] <= sb.st_addr;
         data_q[tail] <= sb.st_data;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         head    <= '0;
         tail    <= '0;
         valid_q <= '0;
         count_q <= '0;
         state   <= IDLE;
      end else begin
         if (pop) begin
            valid_q[head] <= 1'b0;
            head          <= head + PW'(1);
         end
         if (enq) begin
            valid_q[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         count_q <= count_n;
         case (state)
            IDLE: if (count_q != '0) state <= REQ;
            REQ:  if (pop && count_n == '0) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Walk oldest to youngest so the last hit is the one nearest the tail.
   logic [PW-1:0] idx;
   logic          hit;
   logic [AW-1:0] fwd;

   always_comb begin
      idx = '0;
      hit = 1'b0;
      fwd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (valid_q[idx] && addr_q[idx] == sb.ld_addr) begin
            hit = 1'b1;
            fwd = data_q[idx];
         end
      end
   end

   assign sb.ld_hit  = hit;
   assign sb.ld_data = fwd;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single drain, fill/backpressure,
// forwarding, wrap-around ordering, simultaneous push/pop, reset mid-drain.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic CLK = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   store_buffer_if #(.DEPTH(DEPTH), .AW(AW)) sb_if ();

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK   (CLK),
      .reset (reset),
      .sb    (sb_if.slave)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++; if (sb_if.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", sb_if.empty); end
      n_cmp++; if (sb_if.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", sb_if.full); end
      n_cmp++; if (sb_if.st_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", sb_if.st_ready); end
      n_cmp++; if (sb_if.count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", sb_if.count); end
      n_cmp++; if (sb_if.mem_req !== 1'b0 || sb_if.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem req=%b addr=%h exp 0/0", sb_if.mem_req, sb_if.mem_addr); end
      n_cmp++; if (sb_if.ld_hit !== 1'b0 || sb_if.ld_data !== 32'h0) begin n_err++; $display("FAIL reset_ld hit=%b data=%h exp 0/0", sb_if.ld_hit, sb_if.ld_data); end
      #10 reset = 1'b1;
      tick;
   endtask

   task automatic test_single;
      sb_if.st_valid = 1'b1; sb_if.st_addr = 32'h10; sb_if.st_data = 32'hDEADBEEF; sb_if.mem_ack = 1'b1;
      tick;
      sb_if.st_valid = 1'b0;
      n_cmp++; if (sb_if.count !== 3'd1 || sb_if.mem_req !== 1'b0) begin n_err++; $display("FAIL single_n count=%0d req=%b exp 1/0", sb_if.count, sb_if.mem_req); end
      tick;
      n_cmp++; if (sb_if.mem_req !== 1'b1 || sb_if.mem_addr !== 32'h10 || sb_if.mem_wdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_n1 req=%b addr=%h data=%h exp 1/10/deadbeef", sb_if.mem_req, sb_if.mem_addr, sb_if.mem_wdata); end
      tick;
      n_cmp++; if (sb_if.count !== 3'd0 || sb_if.mem_req !== 1'b0 || sb_if.mem_wdata !== 32'h0) begin
         n_err++; $display("FAIL single_n2 count=%0d req=%b data=%h exp 0/0/0", sb_if.count, sb_if.mem_req, sb_if.mem_wdata); end
      sb_if.mem_ack = 1'b0;
   endtask

   task automatic test_fill;
      sb_if.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb_if.st_valid = 1'b1; sb_if.st_addr = 32'(4 * i); sb_if.st_data = 32'h100 + 32'(i);
         tick;
      end
      n_cmp++; if (sb_if.full !== 1'b1 || sb_if.st_ready !== 1'b0) begin n_err++; $display("FAIL fill_full full=%b ready=%b exp 1/0", sb_if.full, sb_if.st_ready); end
      sb_if.st_addr = 32'h40; sb_if.st_data = 32'h55;
      tick;
      sb_if.st_valid = 1'b0;
      n_cmp++; if (sb_if.count !== 3'd4) begin n_err++; $display("FAIL fill_5th count=%0d exp=4", sb_if.count); end
      sb_if.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (sb_if.mem_req !== 1'b1 || sb_if.mem_addr !== 32'(4 * i) || sb_if.mem_wdata !== 32'h100 + 32'(i)) begin
            n_err++; $display("FAIL fill_drain%0d req=%b addr=%h data=%h exp 1/%h/%h", i, sb_if.mem_req, sb_if.mem_addr, sb_if.mem_wdata, 4 * i, 32'h100 + 32'(i)); end
         tick;
      end
      n_cmp++; if (sb_if.count !== 3'd0 || sb_if.mem_req !== 1'b0) begin n_err++; $display("FAIL fill_done count=%0d req=%b exp 0/0", sb_if.count, sb_if.mem_req); end
      sb_if.mem_ack = 1'b0;
   endtask

   task automatic test_forward;
      bit done = 1'b0;
      sb_if.mem_ack = 1'b0; sb_if.ld_addr = 32'h20;
      sb_if.st_valid = 1'b1; sb_if.st_addr = 32'h20; sb_if.st_data = 32'h1;
      tick;
      sb_if.st_data = 32'h2;
      #1;
      n_cmp++; if (sb_if.ld_hit !== 1'b1 || sb_if.ld_data !== 32'h1) begin n_err++; $display("FAIL fwd_same_cycle hit=%b data=%h exp 1/1", sb_if.ld_hit, sb_if.ld_data); end
      tick;
      sb_if.st_valid = 1'b0;
      n_cmp++; if (sb_if.ld_hit !== 1'b1 || sb_if.ld_data !== 32'h2) begin n_err++; $display("FAIL fwd_youngest hit=%b data=%h exp 1/2", sb_if.ld_hit, sb_if.ld_data); end
      sb_if.ld_addr = 32'h24;
      #1;
      n_cmp++; if (sb_if.ld_hit !== 1'b0 || sb_if.ld_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss hit=%b data=%h exp 0/0", sb_if.ld_hit, sb_if.ld_data); end
      sb_if.mem_ack = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         if (sb_if.count == 3'd0 && !sb_if.mem_req) done = 1'b1;
         else tick;
      end
      n_cmp++; if (!done) begin n_err++; $display("FAIL fwd_drain_timeout count=%0d req=%b exp 0/0", sb_if.count, sb_if.mem_req); end
      sb_if.mem_ack = 1'b0;
   endtask

   task automatic test_wrap;
      int  sent = 0, w = 0, maxc = 0;
      bit  acc, wr;
      for (int cyc = 0; cyc < 200 && w < 10; cyc++) begin
         sb_if.st_valid = (sent < 10);
         sb_if.st_addr  = 32'h100 + 32'(4 * sent);
         sb_if.st_data  = 32'(sent * 3 + 7);
         sb_if.mem_ack  = cyc[0];
         #1;
         acc = sb_if.st_valid && sb_if.st_ready;
         wr  = sb_if.mem_req && sb_if.mem_ack;
         if (wr) begin
            n_cmp++; if (sb_if.mem_addr !== 32'h100 + 32'(4 * w) || sb_if.mem_wdata !== 32'(w * 3 + 7)) begin
               n_err++; $display("FAIL wrap_write%0d addr=%h data=%h exp %h/%h", w, sb_if.mem_addr, sb_if.mem_wdata, 32'h100 + 32'(4 * w), w * 3 + 7); end
            w++;
         end
         tick;
         if (acc) sent++;
         if (int'(sb_if.count) > maxc) maxc = int'(sb_if.count);
      end
      sb_if.st_valid = 1'b0; sb_if.mem_ack = 1'b1;
      n_cmp++; if (w != 10 || sent != 10) begin n_err++; $display("FAIL wrap_total writes=%0d sent=%0d exp 10/10", w, sent); end
      n_cmp++; if (maxc > 4) begin n_err++; $display("FAIL wrap_maxcount got=%0d exp<=4", maxc); end
      tick; tick;
      n_cmp++; if (sb_if.count !== 3'd0 || sb_if.mem_req !== 1'b0) begin n_err++; $display("FAIL wrap_dup count=%0d req=%b exp 0/0", sb_if.count, sb_if.mem_req); end
      sb_if.mem_ack = 1'b0;
   endtask

   task automatic test_back_to_back;
      sb_if.mem_ack = 1'b0;
      sb_if.st_valid = 1'b1; sb_if.st_addr = 32'h50; sb_if.st_data = 32'hA;
      tick;
      sb_if.st_addr = 32'h54; sb_if.st_data = 32'hB;
      tick;
      sb_if.st_valid = 1'b0;
      n_cmp++; if (sb_if.count !== 3'd2 || sb_if.mem_req !== 1'b1 || sb_if.mem_addr !== 32'h50) begin
         n_err++; $display("FAIL sim_setup count=%0d req=%b addr=%h exp 2/1/50", sb_if.count, sb_if.mem_req, sb_if.mem_addr); end
      sb_if.mem_ack = 1'b1; sb_if.st_valid = 1'b1; sb_if.st_addr = 32'h58; sb_if.st_data = 32'hC;
      tick;
      sb_if.st_valid = 1'b0; sb_if.mem_ack = 1'b0;
      n_cmp++; if (sb_if.count !== 3'd2 || sb_if.mem_addr !== 32'h54 || sb_if.mem_wdata !== 32'hB) begin
         n_err++; $display("FAIL sim_pushpop count=%0d addr=%h data=%h exp 2/54/b", sb_if.count, sb_if.mem_addr, sb_if.mem_wdata); end
      sb_if.mem_ack = 1'b1;
      tick;
      n_cmp++; if (sb_if.count !== 3'd1 || sb_if.mem_addr !== 32'h58 || sb_if.mem_wdata !== 32'hC) begin
         n_err++; $display("FAIL sim_newest count=%0d addr=%h data=%h exp 1/58/c", sb_if.count, sb_if.mem_addr, sb_if.mem_wdata); end
      tick;
      n_cmp++; if (sb_if.count !== 3'd0 || sb_if.mem_req !== 1'b0) begin n_err++; $display("FAIL sim_done count=%0d req=%b exp 0/0", sb_if.count, sb_if.mem_req); end
      sb_if.mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_drain;
      int spurious = 0;
      sb_if.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb_if.st_valid = 1'b1; sb_if.st_addr = 32'h80 + 32'(4 * i); sb_if.st_data = 32'(i);
         tick;
      end
      sb_if.st_valid = 1'b0;
      n_cmp++; if (sb_if.count !== 3'd3 || sb_if.mem_req !== 1'b1) begin n_err++; $display("FAIL rst_setup count=%0d req=%b exp 3/1", sb_if.count, sb_if.mem_req); end
      sb_if.mem_ack = 1'b1;
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (sb_if.mem_req !== 1'b0 || sb_if.count !== 3'd0 || sb_if.empty !== 1'b1) begin
         n_err++; $display("FAIL rst_async req=%b count=%0d empty=%b exp 0/0/1", sb_if.mem_req, sb_if.count, sb_if.empty); end
      #2 reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick;
         if (sb_if.mem_req !== 1'b0 || sb_if.count !== 3'd0) spurious++;
      end
      n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL rst_after bad_cycles=%0d exp 0", spurious); end
      sb_if.mem_ack = 1'b0;
   endtask

   initial begin
      sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0;
      sb_if.ld_addr = '0; sb_if.mem_ack = 1'b0;
      test_reset;
      test_single;
      test_fill;
      test_forward;
      test_wrap;
      test_back_to_back;
      test_reset_mid_drain;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
